// File: rtl/pwm_event_decimator.sv
// pwm_event_decimator
//   Multi-channel event decimator for the PWM carrier block. Each channel
//   counts rising edges of its carrier event strobe and passes one event out
//   of every (period+1). Output pulses are registered and last one cycle.
//
//   Optional build macro: PWM_EVTDEC_SHADOW_EN
//     defined   : each channel uses a shadow copy of its period that reloads
//                 only at a period boundary (wrap, disabled, cleared or
//                 pass-through), so live period writes never cut a period short.
//     undefined : the live period input is compared on every edge.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high; clears all state
//   event_in   in   [NUM_CH]           per-channel event level/strobe
//   enable     in   [NUM_CH]           per-channel enable; low holds channel idle
//   mask_en    in   [NUM_CH]           1 = decimate, 0 = pass every edge through
//   sync_clr   in   [NUM_CH]           synchronous per-channel counter clear
//   period     in   [NUM_CH*CNT_WIDTH] packed periods, ch i = [i*CNT_WIDTH +: CNT_WIDTH]
//   event_out  out  [NUM_CH]           registered single-cycle decimated pulse
//   count_out  out  [NUM_CH*CNT_WIDTH] packed registered counter values
module pwm_event_decimator #(
  parameter int NUM_CH    = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             event_in,
  input  logic [NUM_CH-1:0]             enable,
  input  logic [NUM_CH-1:0]             mask_en,
  input  logic [NUM_CH-1:0]             sync_clr,
  input  logic [NUM_CH*CNT_WIDTH-1:0]   period,
  output logic [NUM_CH-1:0]             event_out,
  output logic [NUM_CH*CNT_WIDTH-1:0]   count_out
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic                 prev_q;
    logic                 edge_det;
    logic [CNT_WIDTH-1:0] period_i;
    logic [CNT_WIDTH-1:0] act_p;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ev_q, ev_d;

    assign period_i = period[i*CNT_WIDTH +: CNT_WIDTH];
    // prev tracks the input every cycle, even while disabled or cleared,
    // so a level held high across those states never re-counts.
    assign edge_det = event_in[i] & ~prev_q;

`ifdef PWM_EVTDEC_SHADOW_EN
    logic [CNT_WIDTH-1:0] shadow_q, shadow_d;
    logic                 boundary;

    // Any cycle that leaves the counter at a period start is a safe point
    // to adopt the new period.
    assign boundary = ~enable[i] | sync_clr[i] | ~mask_en[i] |
                      (edge_det & (cnt_q >= shadow_q));
    assign shadow_d = boundary ? period_i : shadow_q;
    assign act_p    = shadow_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) shadow_q <= '0;
      else       shadow_q <= shadow_d;
    end
`else
    assign act_p = period_i;
`endif

    always_comb begin
      cnt_d = cnt_q;
      ev_d  = 1'b0;
      if (!enable[i]) begin
        cnt_d = '0;
      end else if (sync_clr[i]) begin
        cnt_d = '0;
      end else if (!mask_en[i]) begin
        cnt_d = '0;
        ev_d  = edge_det;
      end else if (edge_det) begin
        // >= rather than == so a live period decrease below the current
        // count wraps on the next edge instead of running to overflow.
        if (cnt_q >= act_p) begin
          cnt_d = '0;
          ev_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        prev_q <= 1'b0;
        cnt_q  <= '0;
        ev_q   <= 1'b0;
      end else begin
        prev_q <= event_in[i];
        cnt_q  <= cnt_d;
        ev_q   <= ev_d;
      end
    end

    assign event_out[i]                         = ev_q;
    assign count_out[i*CNT_WIDTH +: CNT_WIDTH]  = cnt_q;
  end

endmodule
